// File: rtl/ec11_quad_gen.sv
// EC11 quadrature generator: queued detent steps played out as s1/s2 waveforms.
// Ports: clk, rst (async, active low), step_valid/step_dir/step_ready push
//   side; s1/s2 quadrature outputs; busy, step_done pulse, pos (mod 8) status.
module ec11_quad_gen #(
   parameter int PHASE_CYC = 100000,
   parameter int GAP_CYC   = 100000,
   parameter int CNT_W     = 20,
   parameter int DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_valid,
   input  logic       step_dir,
   output logic       step_ready,
   output logic       s1,
   output logic       s2,
   output logic       busy,
   output logic       step_done,
   output logic [2:0] pos
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PH1  = 3'd1;
   localparam logic [2:0] PH2  = 3'd2;
   localparam logic [2:0] PH3  = 3'd3;
   localparam logic [2:0] GAP  = 3'd4;

   localparam logic [CNT_W-1:0] PH_LD  = CNT_W'(PHASE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

   logic [DEPTH-1:0] fifo_q;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             dir;
   logic             fin;
   logic [1:0]       lvl;
   logic             cnt_zero;

   assign full       = (count == (AW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign push       = step_valid & ~full;
   assign pop        = (state == IDLE) & ~empty;
   assign step_ready = ~full;
   assign busy       = (state != IDLE) | ~empty;
   assign cnt_zero   = (cnt == '0);

   // Direction FIFO; a full FIFO refuses even when a pop happens this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= step_dir;
            wr_ptr         <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         dir   <= 1'b0;
         fin   <= 1'b0;
      end else begin
         fin <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  dir   <= fifo_q[rd_ptr];
                  cnt   <= PH_LD;
                  state <= PH1;
               end
            end
            PH1: begin
               if (cnt_zero) begin
                  cnt   <= PH_LD;
                  state <= PH2;
               end else begin
                  cnt <= cnt - CNT_1;
               end
            end
            PH2: begin
               if (cnt_zero) begin
                  cnt   <= PH_LD;
                  state <= PH3;
               end else begin
                  cnt <= cnt - CNT_1;
               end
            end
            PH3: begin
               if (cnt_zero) begin
                  cnt   <= GAP_LD;
                  state <= GAP;
                  fin   <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_1;
               end
            end
            GAP: begin
               if (cnt_zero) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Right: 10,00,01 (s2 rises with s1 low); left mirrors it.
   always_comb begin
      lvl = 2'b11;
      unique case (1'b1)
         (state == PH1): lvl = dir ? 2'b10 : 2'b01;
         (state == PH2): lvl = 2'b00;
         (state == PH3): lvl = dir ? 2'b01 : 2'b10;
         default:        lvl = 2'b11;
      endcase
   end

   // Outputs trail the FSM by one clock, so the step completion (fin)
   // lands on the same edge where s1/s2 return to 11.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1        <= 1'b1;
         s2        <= 1'b1;
         step_done <= 1'b0;
         pos       <= '0;
      end else begin
         s1        <= lvl[1];
         s2        <= lvl[0];
         step_done <= fin;
         if (fin) begin
            pos <= pos + (dir ? 3'd1 : 3'd7);
         end
      end
   end

endmodule

// File: tb/tb_ec11_quad_gen.sv
// Testbench for ec11_quad_gen: timeline model of accepted steps plus
// directed vectors with hand-computed waveform expectations.
module tb_ec11_quad_gen;

   localparam int P = 4;
   localparam int G = 2;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       step_valid;
   logic       step_dir;
   logic       step_ready;
   logic       s1;
   logic       s2;
   logic       busy;
   logic       step_done;
   logic [2:0] pos;

   ec11_quad_gen #(
      .PHASE_CYC(P),
      .GAP_CYC  (G),
      .CNT_W    (8),
      .DEPTH    (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .step_valid(step_valid),
      .step_dir  (step_dir),
      .step_ready(step_ready),
      .s1        (s1),
      .s2        (s2),
      .busy      (busy),
      .step_done (step_done),
      .pos       (pos)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit chk_on = 1'b0;

   // Model: each accepted step has an accept edge, a first-output cycle
   // and a direction; everything else is derived from those.
   int m_a [64];
   int m_t [64];
   bit m_d [64];
   int m_n = 0;
   int nc;
   int tt;

   int dec = 0;
   int rt = 0;
   int lt = 0;
   logic prev_s2 = 1'b1;
   logic [1:0] prev_ss = 2'b11;
   logic [7:0] ce;
   logic [7:0] ca;

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   function automatic int mdl_occ(int c);
      int n = 0;
      for (int i = 0; i < m_n; i++)
         if (m_a[i] <= c && m_t[i] - 1 > c) n++;
      return n;
   endfunction

   function automatic logic [1:0] mdl_lvl(bit d, int ph);
      if (ph == 1) return 2'b00;
      if (ph == 0) return d ? 2'b10 : 2'b01;
      return d ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [7:0] mdl_exp(int c);
      logic [1:0] lv = 2'b11;
      logic dn = 1'b0;
      logic bz = 1'b0;
      logic rdy;
      int sum = 0;
      for (int i = 0; i < m_n; i++) begin
         if (c >= m_t[i] && c < m_t[i] + 3*P)
            lv = mdl_lvl(m_d[i], (c - m_t[i]) / P);
         if (c == m_t[i] + 3*P) dn = 1'b1;
         if (c >= m_t[i] + 3*P) sum += m_d[i] ? 1 : -1;
         if (c >= m_a[i] && c <= m_t[i] + 3*P + G - 2) bz = 1'b1;
      end
      rdy = (mdl_occ(c) < D);
      return {lv, dn, sum[2:0], bz, rdy};
   endfunction

   always @(posedge clk) begin
      nc = cyc + 1;
      if (!rst) begin
         m_n = 0;
      end else if (step_valid && mdl_occ(cyc) < D) begin
         tt = nc + 2;
         if (m_n > 0 && m_t[m_n-1] + 3*P + G + 1 > tt)
            tt = m_t[m_n-1] + 3*P + G + 1;
         m_a[m_n] = nc;
         m_t[m_n] = tt;
         m_d[m_n] = step_dir;
         m_n++;
      end
      cyc = nc;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         ca = {s1, s2, step_done, pos, busy, step_ready};
         ce = rst ? mdl_exp(cyc) : 8'b11000001;
         chk("cycle", int'(ca), int'(ce));
         if (rst)
            chk("gray", int'((prev_ss ^ {s1, s2}) == 2'b11), 0);
      end
      prev_ss = {s1, s2};
   end

   // Independent decoder: an s2 rise with s1 low is a right detent.
   always @(negedge clk) begin
      if (rst && !prev_s2 && s2) begin
         if (!s1) begin
            rt++;
            dec++;
         end else begin
            lt++;
            dec--;
         end
      end
      prev_s2 = s2;
   end

   task automatic wait_cyc(int t);
      if (cyc > t) chk("sched", cyc, t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic push(bit d, output int a);
      int st;
      int k;
      st = m_n;
      k = 0;
      step_valid = 1'b1;
      step_dir = d;
      do begin
         @(negedge clk);
         k++;
      end while (m_n == st && k < 200);
      if (m_n == st) begin
         chk("push_timeout", 0, 1);
         a = cyc;
      end else begin
         a = m_a[m_n-1];
      end
   endtask

   task automatic wait_idle();
      int e;
      e = (m_n > 0) ? m_t[m_n-1] + 3*P + G + 2 : cyc;
      wait_cyc(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   function automatic int ss();
      return int'({s1, s2});
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int a;
      int a1;
      int a5;
      rst = 1'b1;
      step_valid = 1'b0;
      step_dir = 1'b0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_on = 1'b1;
      chk("rst_s1s2", ss(), 'b11);
      chk("rst_pos", int'(pos), 0);
      chk("rst_ready", int'(step_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(step_done), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rel_s1s2", ss(), 'b11);
      chk("rel_busy", int'(busy), 0);

      push(1'b1, a);
      step_valid = 1'b0;
      wait_cyc(a + 1);  chk("r_c1", ss(), 'b11);
      wait_cyc(a + 2);  chk("r_c2", ss(), 'b10);
      wait_cyc(a + 5);  chk("r_c5", ss(), 'b10);
      wait_cyc(a + 6);  chk("r_c6", ss(), 'b00);
      wait_cyc(a + 10); chk("r_c10", ss(), 'b01);
      wait_cyc(a + 13);
      chk("r_c13", int'({s1, s2, step_done}), 'b010);
      wait_cyc(a + 14);
      chk("r_c14", int'({s1, s2, step_done}), 'b111);
      chk("r_pos", int'(pos), 1);
      wait_cyc(a + 15);
      chk("r_done_off", int'(step_done), 0);
      chk("r_busy_off", int'(busy), 0);

      do_reset();
      push(1'b0, a);
      step_valid = 1'b0;
      wait_cyc(a + 2);  chk("l_c2", ss(), 'b01);
      wait_cyc(a + 6);  chk("l_c6", ss(), 'b00);
      wait_cyc(a + 10); chk("l_c10", ss(), 'b10);
      wait_cyc(a + 14);
      chk("l_c14", int'({s1, s2, step_done}), 'b111);
      chk("l_pos", int'(pos), 7);
      wait_cyc(a + 15);
      chk("l_done_off", int'(step_done), 0);

      do_reset();
      push(1'b1, a1);
      push(1'b1, a);
      push(1'b0, a);
      push(1'b1, a);
      push(1'b1, a5);
      step_valid = 1'b0;
      chk("full_ready", int'(step_ready), 0);
      chk("full_b2b", a5 - a1, 4);
      wait_idle();
      chk("full_pos", int'(pos), 3);

      do_reset();
      dec = 0;
      rt = 0;
      lt = 0;
      for (int i = 0; i < 8; i++) begin
         push(1'b1, a);
         if (i == 0) a1 = a;
         if (i == 5) a5 = a;
      end
      step_valid = 1'b0;
      chk("held_6th", a5 - a1, 17);
      wait_idle();
      chk("lb_pos", int'(pos), 0);
      chk("lb_dec", dec & 7, 0);
      chk("lb_right", rt, 8);
      chk("lb_left", lt, 0);

      do_reset();
      push(1'b1, a);
      push(1'b1, a1);
      push(1'b1, a1);
      step_valid = 1'b0;
      wait_cyc(a + 7);
      chk("mid_ph2", ss(), 'b00);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("ar_s1s2", ss(), 'b11);
      chk("ar_pos", int'(pos), 0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_ready", int'(step_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      a = cyc;
      wait_cyc(a + 40);
      chk("post_s1s2", ss(), 'b11);
      chk("post_pos", int'(pos), 0);
      chk("post_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
